irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter N_SRC, default 4, number of interrupt sources; legal range 1..32.
REQ-002 Parameter EXC_VEC, default 32'h80000008, exception handler address.
REQ-003 Parameter IRQ_VEC, default 32'h80000004, common interrupt handler address.
REQ-004 Parameter VEC_BASE, default 32'h80000010, vectored-mode table base.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 reset  in  1  synchronous, active-low; sampled on posedge clk.
REQ-007 irq_src  in  N_SRC  interrupt source lines, level inputs, rising-edge detected.
REQ-008 exc  in  1  exception strobe (overflow or illegal PC), one-cycle pulse.
REQ-009 pc_in  in  32  PC of the interrupted instruction.
REQ-010 mask_we  in  1  mask write enable.
REQ-011 mask_wdata  in  N_SRC  new mask value; bit=1 enables that source.
REQ-012 irq_ack  in  1  CPU has redirected PC to vec.
REQ-013 eret  in  1  handler return.
REQ-014 req  out  1  request to redirect PC.
REQ-015 vec  out  32  target address, valid while req=1.
REQ-016 cause  out  8  bit7=exception, [4:0]=source id; valid from req until eret.
REQ-017 epc  out  32  captured return PC.
REQ-018 pending  out  N_SRC, and mask  out  N_SRC: status readback.
REQ-019 kernel  out  1  high in SERVICE state.
REQ-020 double_fault  out  1  sticky warning flag.

Function
REQ-021 A source whose irq_src is sampled 1 with its previous sample 0 SHALL set its pending bit on that same edge; the bit stays set until acknowledged.
REQ-022 States IDLE, REQ, SERVICE; IDLE->REQ when exc=1 or (pending & mask) != 0.
REQ-023 On IDLE->REQ, vec and cause SHALL be latched: exc has priority over interrupts; among interrupts the lowest index wins.
REQ-024 req SHALL be 1 exactly while in REQ; vec and cause SHALL be held stable while in REQ.
REQ-025 REQ->SERVICE on irq_ack: epc<=pc_in; the served pending bit is cleared, unless a new rising edge on the same source arrives in that cycle, in which case the bit stays set.
REQ-026 An exc in REQ while an interrupt is being requested SHALL replace vec/cause with the exception; the interrupt's pending bit is kept.
REQ-027 An exc in SERVICE SHALL set double_fault; no new request, state is unchanged.
REQ-028 SERVICE->IDLE on eret; eret outside SERVICE and irq_ack outside REQ are ignored.
REQ-029 No nesting: pending interrupts wait in SERVICE and are requested after eret, from IDLE.
REQ-030 A mask_we write takes effect on the next edge; masking affects only request generation, never pending capture.

Reset
REQ-031 With reset=0 at posedge: state=IDLE; req=0, vec=0, cause=0, epc=0, pending=0, kernel=0, double_fault=0, mask=all ones, edge history=0.
REQ-032 Reset during REQ or SERVICE SHALL abort the state without an ack or eret; pending edges are lost.

Configuration
REQ-033 Macro IRQ_CTRL_VECTORED_EN defined: interrupt vec = VEC_BASE + 8*id. Undefined: every interrupt uses IRQ_VEC. EXC_VEC is used in both cases.

Structure
REQ-034 Package irq_pkg SHALL hold the state enum, the default vector constants, and the cause-bit positions.
REQ-035 Sub-module irq_prio_enc SHALL be the parametrised lowest-index priority encoder, with outputs valid and id.

Verification
REQ-036 Reset with irq_src=0 -> all outputs at their reset values; mask=4'b1111.
REQ-037 Rise irq_src[2] -> req=1 on the next cycle, vec=32'h80000004 (or 32'h80000020 vectored), cause=8'h02; after ack, epc=pc_in and pending[2]=0.
REQ-038 Rise irq_src[3] and irq_src[1] together -> cause=8'h01 first; after eret, cause=8'h03.
REQ-039 Pulse exc while requesting source 1 -> vec=32'h80000008, cause=8'h80, pending[1] stays 1.
REQ-040 Pulse exc in SERVICE -> double_fault=1 and stays 1 until reset; req stays 0.
REQ-041 mask=4'b1011 and a rise on irq_src[2] -> pending[2]=1 with req=0; write mask=4'b1111 -> req=1 on the next cycle.

Source files
------------

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the interrupt controller
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [31:0] DEF_EXC_VEC  = 32'h8000_0008;
    localparam logic [31:0] DEF_IRQ_VEC  = 32'h8000_0004;
    localparam logic [31:0] DEF_VEC_BASE = 32'h8000_0010;

    // cause layout: bit 7 flags an exception, bits 4:0 carry the source id
    localparam int CAUSE_EXC_BIT = 7;
    localparam int CAUSE_ID_MSB  = 4;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder
// Ports: bits (request vector), valid (any bit set), id (index of lowest set bit).
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] bits,
    output logic         valid,
    output logic [4:0]   id
);

    always_comb begin
        valid = |bits;
        id    = 5'd0;
        // scan downward so the lowest set index is the last one written
        for (int i = N - 1; i >= 0; i--) begin
            if (bits[i]) begin
                id = i[4:0];
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - single-level interrupt/exception controller
// Optional feature macro: IRQ_CTRL_VECTORED_EN (interrupt vec = VEC_BASE + 8*id).
// Ports: clk, reset (sync active-low); irq_src edge-detected sources; exc strobe;
//        pc_in; mask_we/mask_wdata; irq_ack, eret handshakes; req/vec/cause
//        request outputs; epc; pending/mask status; kernel; double_fault.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          N_SRC    = 4,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC,
    parameter logic [31:0] IRQ_VEC  = DEF_IRQ_VEC,
    parameter logic [31:0] VEC_BASE = DEF_VEC_BASE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             exc,
    input  logic [31:0]      pc_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             irq_ack,
    input  logic             eret,
    output logic             req,
    output logic [31:0]      vec,
    output logic [7:0]       cause,
    output logic [31:0]      epc,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask,
    output logic             kernel,
    output logic             double_fault
);

    state_t           state;
    logic [N_SRC-1:0] irq_prev;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] clr;
    logic             enc_valid;
    logic [4:0]       enc_id;
    logic [31:0]      irq_vec_sel;
    logic             ack_fire;

    assign rise   = irq_src & ~irq_prev;
    assign active = pending & mask;
    assign req    = (state == ST_REQ);
    assign kernel = (state == ST_SERVICE);

    irq_prio_enc #(.N(N_SRC)) u_prio_enc (
        .bits  (active),
        .valid (enc_valid),
        .id    (enc_id)
    );

`ifdef IRQ_CTRL_VECTORED_EN
    assign irq_vec_sel = VEC_BASE + {24'd0, enc_id, 3'd0};
`else
    assign irq_vec_sel = IRQ_VEC;
`endif

    // an exc in the same cycle as the ack wins: the request is retargeted
    // to the exception and the ack is not taken
    assign ack_fire = (state == ST_REQ) && irq_ack && !exc;

    // clear the served source only when an interrupt (not an exception) was
    // acknowledged; a simultaneous new rise re-sets it via the OR below
    always_comb begin
        clr = '0;
        if (ack_fire && !cause[CAUSE_EXC_BIT]) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (cause[CAUSE_ID_MSB:0] == i[4:0]) begin
                    clr[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            irq_prev     <= '0;
            pending      <= '0;
            mask         <= '1;
            vec          <= 32'd0;
            cause        <= 8'd0;
            epc          <= 32'd0;
            double_fault <= 1'b0;
        end else begin
            irq_prev <= irq_src;
            pending  <= (pending & ~clr) | rise;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            case (state)
                ST_IDLE: begin
                    if (exc) begin
                        state <= ST_REQ;
                        vec   <= EXC_VEC;
                        cause <= 8'h80;
                    end else if (enc_valid) begin
                        state <= ST_REQ;
                        vec   <= irq_vec_sel;
                        cause <= {3'b000, enc_id};
                    end
                end
                ST_REQ: begin
                    if (exc) begin
                        vec   <= EXC_VEC;
                        cause <= 8'h80;
                    end else if (irq_ack) begin
                        state <= ST_SERVICE;
                        epc   <= pc_in;
                    end
                end
                ST_SERVICE: begin
                    if (exc) begin
                        double_fault <= 1'b1;
                    end
                    if (eret) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed self-checking bench for irq_controller
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_src;
    logic        exc;
    logic [31:0] pc_in;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        irq_ack;
    logic        eret;
    logic        req;
    logic [31:0] vec;
    logic [7:0]  cause;
    logic [31:0] epc;
    logic [3:0]  pending;
    logic [3:0]  mask;
    logic        kernel;
    logic        double_fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    irq_controller dut (
        .clk          (clk),
        .reset        (reset),
        .irq_src      (irq_src),
        .exc          (exc),
        .pc_in        (pc_in),
        .mask_we      (mask_we),
        .mask_wdata   (mask_wdata),
        .irq_ack      (irq_ack),
        .eret         (eret),
        .req          (req),
        .vec          (vec),
        .cause        (cause),
        .epc          (epc),
        .pending      (pending),
        .mask         (mask),
        .kernel       (kernel),
        .double_fault (double_fault)
    );

    function automatic logic [31:0] exp_irq_vec(input int id);
`ifdef IRQ_CTRL_VECTORED_EN
        return 32'h8000_0010 + 32'(8 * id);
`else
        return 32'h8000_0004;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; irq_src = 4'b0; exc = 1'b0; pc_in = 32'd0;
        mask_we = 1'b0; mask_wdata = 4'b0; irq_ack = 1'b0; eret = 1'b0;
        @(negedge clk);
        tick(); tick();
        check("rst_req", 32'(req), 32'd0);
        check("rst_vec", vec, 32'd0);
        check("rst_cause", 32'(cause), 32'd0);
        check("rst_epc", epc, 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_mask", 32'(mask), 32'hf);
        check("rst_kernel", 32'(kernel), 32'd0);
        check("rst_dfault", 32'(double_fault), 32'd0);
        reset = 1'b1;

        // single source 2
        irq_src = 4'b0100; tick();
        check("s2_pending", 32'(pending), 32'h4);
        check("s2_req_early", 32'(req), 32'd0);
        tick();
        check("s2_req", 32'(req), 32'd1);
        check("s2_vec", vec, exp_irq_vec(2));
        check("s2_cause", 32'(cause), 32'h02);
        pc_in = 32'h0000_1234; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("s2_kernel", 32'(kernel), 32'd1);
        check("s2_req_off", 32'(req), 32'd0);
        check("s2_epc", epc, 32'h0000_1234);
        check("s2_pend_clr", 32'(pending), 32'd0);
        check("s2_cause_hold", 32'(cause), 32'h02);
        eret = 1'b1; tick(); eret = 1'b0;
        check("s2_eret", 32'(kernel), 32'd0);
        irq_src = 4'b0; tick();

        // sources 3 and 1 together: 1 first, 3 after eret
        irq_src = 4'b1010; tick();
        check("p_pending", 32'(pending), 32'ha);
        tick();
        check("p_cause1", 32'(cause), 32'h01);
        check("p_vec1", vec, exp_irq_vec(1));
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("p_pend_after1", 32'(pending), 32'h8);
        check("p_nonest", 32'(req), 32'd0);
        eret = 1'b1; tick(); eret = 1'b0;
        check("p_idle", 32'(req), 32'd0);
        tick();
        check("p_req3", 32'(req), 32'd1);
        check("p_cause3", 32'(cause), 32'h03);
        check("p_vec3", vec, exp_irq_vec(3));
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        irq_src = 4'b0; tick();
        check("p_drained", 32'(pending), 32'd0);

        // exception replaces pending request, then double fault
        irq_src = 4'b0010; tick(); tick();
        check("e_cause1", 32'(cause), 32'h01);
        exc = 1'b1; tick(); exc = 1'b0;
        check("e_vec", vec, 32'h8000_0008);
        check("e_cause", 32'(cause), 32'h80);
        check("e_pend_kept", 32'(pending), 32'h2);
        check("e_req", 32'(req), 32'd1);
        pc_in = 32'h0000_2000; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("e_kernel", 32'(kernel), 32'd1);
        check("e_pend_svc", 32'(pending), 32'h2);
        check("e_epc", epc, 32'h0000_2000);
        exc = 1'b1; tick(); exc = 1'b0;
        check("df_set", 32'(double_fault), 32'd1);
        check("df_noreq", 32'(req), 32'd0);
        check("df_kernel", 32'(kernel), 32'd1);
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        check("e_rereq", 32'(req), 32'd1);
        check("e_recause", 32'(cause), 32'h01);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("e_pend_clr", 32'(pending), 32'd0);
        eret = 1'b1; tick(); eret = 1'b0;
        check("df_sticky", 32'(double_fault), 32'd1);
        irq_src = 4'b0;

        reset = 1'b0; tick(); reset = 1'b1;
        check("df_reset", 32'(double_fault), 32'd0);

        // masking affects requests but not capture
        mask_we = 1'b1; mask_wdata = 4'b1011; tick(); mask_we = 1'b0;
        check("m_mask", 32'(mask), 32'hb);
        irq_src = 4'b0100; tick();
        check("m_pending", 32'(pending), 32'h4);
        check("m_noreq0", 32'(req), 32'd0);
        tick();
        check("m_noreq1", 32'(req), 32'd0);
        mask_we = 1'b1; mask_wdata = 4'b1111; tick(); mask_we = 1'b0;
        check("m_wr_edge", 32'(req), 32'd0);
        tick();
        check("m_req", 32'(req), 32'd1);
        check("m_cause", 32'(cause), 32'h02);

        // new rise on served source during ack keeps pending
        irq_src = 4'b0; tick();
        check("r_still_req", 32'(req), 32'd1);
        irq_src = 4'b0100; irq_ack = 1'b1; tick();
        check("r_kernel", 32'(kernel), 32'd1);
        check("r_pend_kept", 32'(pending), 32'h4);
        tick(); irq_ack = 1'b0;
        check("r_ack_ignored", 32'(kernel), 32'd1);

        // reset aborts service and drops pending edges
        irq_src = 4'b0; reset = 1'b0; tick(); reset = 1'b1;
        check("a_kernel", 32'(kernel), 32'd0);
        check("a_pending", 32'(pending), 32'd0);
        check("a_cause", 32'(cause), 32'd0);
        tick();
        check("a_noreq", 32'(req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
